// File: rtl/imem_loader.sv
// imem_loader: loads the core's instruction memory from a byte stream.
// Stream: len[7:0], len[15:8], words (little-endian), XOR checksum byte.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   start             one-cycle request to begin a load
//   in_valid/in_data  byte source
//   in_ready          byte accepted this cycle (combinational)
//   mem_we/addr/wdata instruction-memory write port, one pulse per word
//   cpu_rst_n         active-low reset to the core
//   busy/done/err     load status (done/err sticky until next start)
//   words_loaded      words written in the current/last load
module imem_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    logic [2:0]  state_q, state_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] words_q, words_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  csum_q, csum_d;
    logic [23:0] word_q, word_d;

    logic        accept;
    logic [15:0] len_full;
    logic [15:0] words_inc;

    assign in_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
    assign accept    = in_valid && in_ready;
    assign len_full  = {in_data, len_q[7:0]};
    assign words_inc = words_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_n_d = cpu_rst_n_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        words_d     = words_q;
        len_d       = len_q;
        lane_d      = lane_q;
        csum_d      = csum_q;
        word_d      = word_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // Core runs in IDLE/DONE; ERR keeps it held.
                cpu_rst_n_d = (state_q != S_ERR);
                if (start) begin
                    state_d     = S_LEN0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    cpu_rst_n_d = 1'b0;
                    words_d     = 16'd0;
                    csum_d      = 8'd0;
                    lane_d      = 2'd0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_d   = {8'd0, in_data};
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d = len_full;
                    if ({1'b0, len_full} > DEPTH_W) begin
                        state_d = S_ERR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    case (lane_q)
                        2'd0: word_d[7:0]   = in_data;
                        2'd1: word_d[15:8]  = in_data;
                        2'd2: word_d[23:16] = in_data;
                        default: begin
                            // Word complete: address from pre-increment count.
                            mem_we_d    = 1'b1;
                            mem_addr_d  = BASE_ADDR +
                                          {14'd0, words_q, 2'b00};
                            mem_wdata_d = {in_data, word_q};
                            words_d     = words_inc;
                            if (words_inc == len_q) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                    lane_d = lane_q + 2'd1;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= 16'd0;
            len_q       <= 16'd0;
            lane_q      <= 2'd0;
            csum_q      <= 8'd0;
            word_q      <= 24'd0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            words_q     <= words_d;
            len_q       <= len_d;
            lane_q      <= lane_d;
            csum_q      <= csum_d;
            word_q      <= word_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule
